// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage access controller and the memory.
// The controller drives request, direction, address and write data; the memory
// answers with a one-cycle ack strobe and read data.
interface mem_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller.
// Turns a load/store in the EX/MEM register into exactly one registered memory
// request, stalls the pipeline until the memory acks, then spends one DONE
// cycle so MEM/WB can capture the result. Misaligned accesses are flagged and
// dropped without stalling.
// Optional feature: define MEM_TIMEOUT_EN to abort a request that has not been
// acked after TIMEOUT_CYCLES REQ cycles (mem_err pulse, ReadData_M cleared).
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   MemRead_M,
    input  logic                   MemWrite_M,
    input  logic [31:0]            ALUResult_M,
    input  logic [31:0]            WriteData_M,
    mem_access_ctrl_if.master      mem,
    output logic [31:0]            ReadData_M,
    output logic                   stall_M,
    output logic                   misalign_M,
    output logic                   mem_err
);

    // A zero limit would abort every request before memory could answer.
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t state;

    logic access;
    logic aligned;

    assign access  = MemRead_M | MemWrite_M;
    assign aligned = (ALUResult_M[1:0] == 2'b00);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] tmo_cnt;
    logic [CntW-1:0] tmo_next;
    logic            mem_err_q;

    assign tmo_next = tmo_cnt + CntW'(1);
    assign mem_err  = mem_err_q;
`else
    assign mem_err = 1'b0;
`endif

    // Stall while an aligned access is waiting to issue or is outstanding.
    always_comb begin
        stall_M = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE:    stall_M = access & aligned;
                REQ:     stall_M = 1'b1;
                default: stall_M = 1'b0;
            endcase
        end
    end

    // Access FSM with all bus and status outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'h0;
            mem.mem_wdata <= 32'h0;
            ReadData_M    <= 32'h0;
            misalign_M    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            mem_err_q     <= 1'b0;
            tmo_cnt       <= '0;
`endif
        end else begin
            misalign_M <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            mem_err_q  <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (access) begin
                        if (aligned) begin
                            mem.mem_addr  <= ALUResult_M;
                            mem.mem_wdata <= WriteData_M;
                            // A simultaneous read+write is treated as a write.
                            mem.mem_we    <= MemWrite_M;
                            mem.mem_req   <= 1'b1;
`ifdef MEM_TIMEOUT_EN
                            tmo_cnt       <= '0;
`endif
                            state         <= REQ;
                        end else begin
                            misalign_M <= 1'b1;
                            ReadData_M <= 32'h0;
                        end
                    end
                end
                REQ: begin
                    // Ack beats a timeout landing in the same cycle.
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                        if (!mem.mem_we) begin
                            ReadData_M <= mem.mem_rdata;
                        end
                        state <= DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (tmo_next == CntW'(TIMEOUT_CYCLES)) begin
                        mem.mem_req <= 1'b0;
                        mem_err_q   <= 1'b1;
                        ReadData_M  <= 32'h0;
                        state       <= DONE;
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed accesses push expected request and
// completion records into queues; a negedge monitor pops and compares them
// whenever the DUT raises/drops mem_req or pulses misalign_M.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        MemRead_M;
    logic        MemWrite_M;
    logic [31:0] ALUResult_M;
    logic [31:0] WriteData_M;
    logic [31:0] ReadData_M;
    logic        stall_M;
    logic        misalign_M;
    logic        mem_err;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .MemRead_M   (MemRead_M),
        .MemWrite_M  (MemWrite_M),
        .ALUResult_M (ALUResult_M),
        .WriteData_M (WriteData_M),
        .mem         (bus),
        .ReadData_M  (ReadData_M),
        .stall_M     (stall_M),
        .misalign_M  (misalign_M),
        .mem_err     (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          stall;
    } cpl_t;

    req_t        req_q[$];
    cpl_t        cpl_q[$];
    logic [31:0] mis_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] rd_model;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic rst_seen  = 1'b0;
    logic req_prev  = 1'b0;
    int   stall_cnt = 0;
    req_t cur_req;

    always @(posedge clk) rst_seen = rst;

    always @(negedge clk) begin
        if (rst_seen) begin
            chk("reset_outputs",
                {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                 ReadData_M, misalign_M, mem_err}, '0);
            if (rst) chk("reset_stall", stall_M, 1'b0);
        end

        if (bus.mem_req && !req_prev) begin
            if (req_q.size() == 0) begin
                chk("unexpected_request", bus.mem_addr, '1);
            end else begin
                cur_req = req_q.pop_front();
                chk("req_fields", {bus.mem_we, bus.mem_addr, bus.mem_wdata},
                    {cur_req.we, cur_req.addr, cur_req.wdata});
            end
        end else if (bus.mem_req) begin
            chk("req_stable", {bus.mem_we, bus.mem_addr, bus.mem_wdata},
                {cur_req.we, cur_req.addr, cur_req.wdata});
        end

        if (!bus.mem_req && req_prev) begin
            if (cpl_q.size() == 0) begin
                chk("unexpected_completion", ReadData_M, '1);
            end else begin
                cpl_t c;
                c = cpl_q.pop_front();
                chk("cpl_rdata", ReadData_M, c.rdata);
                chk("cpl_err", mem_err, c.err);
                chk("cpl_stall_cycles", stall_cnt, c.stall);
            end
            stall_cnt = 0;
        end

        if (misalign_M) begin
            if (mis_q.size() == 0) begin
                chk("unexpected_misalign", misalign_M, 1'b0);
            end else begin
                void'(mis_q.pop_front());
                chk("mis_rdata_zero", ReadData_M, 32'h0);
                chk("mis_no_req", bus.mem_req, 1'b0);
                chk("mis_no_stall", stall_cnt, 0);
            end
            stall_cnt = 0;
        end

        if (stall_M) stall_cnt++;
        req_prev = bus.mem_req;
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One aligned access: one IDLE cycle, req_cycles REQ cycles (ack on
    // ack_cycle, 0 = never), then one DONE cycle.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int ack_cycle, input int req_cycles,
                          input logic done_ack, input logic exp_err);
        req_t r;
        cpl_t c;
        r.we    = wr;
        r.addr  = addr;
        r.wdata = wdata;
        req_q.push_back(r);
        if (exp_err)  rd_model = 32'h0;
        else if (!wr) rd_model = rdata;
        c.rdata = rd_model;
        c.err   = exp_err;
        c.stall = 1 + req_cycles;
        cpl_q.push_back(c);

        MemRead_M   = rd;
        MemWrite_M  = wr;
        ALUResult_M = addr;
        WriteData_M = wdata;
        @(posedge clk);
        #1;
        for (int k = 1; k <= req_cycles; k++) begin
            bus.mem_ack   = (k == ack_cycle);
            bus.mem_rdata = (k == ack_cycle) ? rdata : 32'hDEAD_BEEF;
            @(posedge clk);
            #1;
        end
        bus.mem_ack   = done_ack;
        bus.mem_rdata = 32'h0BAD_0BAD;
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        MemRead_M   = 1'b0;
        MemWrite_M  = 1'b0;
    endtask

    task automatic misaligned(input logic rd, input logic wr, input logic [31:0] addr);
        mis_q.push_back(addr);
        rd_model    = 32'h0;
        MemRead_M   = rd;
        MemWrite_M  = wr;
        ALUResult_M = addr;
        @(posedge clk);
        #1;
        MemRead_M  = 1'b0;
        MemWrite_M = 1'b0;
    endtask

    task automatic reset_in_req();
        req_t r;
        cpl_t c;
        r.we    = 1'b0;
        r.addr  = 32'h0000_0040;
        r.wdata = 32'h7777_7777;
        req_q.push_back(r);
        rd_model = 32'h0;
        c.rdata  = 32'h0;
        c.err    = 1'b0;
        c.stall  = 2;
        cpl_q.push_back(c);

        MemRead_M   = 1'b1;
        ALUResult_M = 32'h0000_0040;
        WriteData_M = 32'h7777_7777;
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        MemRead_M     = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        MemRead_M     = 1'b0;
        MemWrite_M    = 1'b0;
        ALUResult_M   = 32'h0;
        WriteData_M   = 32'h0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        rd_model      = 32'h0;
        idle(3);
        rst = 1'b0;
        idle(2);

        access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 1, 1, 1'b0, 1'b0);
        idle(2);
        access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hFFFF_FFFF, 5, 5, 1'b0, 1'b0);
        idle(2);
        misaligned(1'b1, 1'b0, 32'h0000_0013);
        idle(2);
        // Read and write together behave as a store.
        access(1'b1, 1'b1, 32'h0000_0030, 32'hA5A5_5A5A, 32'h1357_9BDF, 2, 2, 1'b0, 1'b0);
        idle(1);
        // Back-to-back loads; a stray ack in the first DONE cycle must be ignored.
        access(1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'h1111_0000, 1, 1, 1'b1, 1'b0);
        access(1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'h2222_0000, 2, 2, 1'b0, 1'b0);
        // Stray ack while idle.
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h9999_9999;
        idle(1);
        bus.mem_ack = 1'b0;
        idle(1);
        misaligned(1'b0, 1'b1, 32'h0000_0022);
        access(1'b1, 1'b0, 32'h0000_0024, 32'h0, 32'h2424_2424, 1, 1, 1'b0, 1'b0);
        idle(1);
        reset_in_req();
        idle(2);
`ifdef MEM_TIMEOUT_EN
        access(1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'h0, 0, 4, 1'b0, 1'b1);
        idle(1);
        access(1'b1, 1'b0, 32'h0000_0084, 32'h0, 32'h8484_8484, 4, 4, 1'b0, 1'b0);
`else
        access(1'b1, 1'b0, 32'h0000_0084, 32'h0, 32'h8484_8484, 12, 12, 1'b0, 1'b0);
`endif
        idle(4);

        chk("req_queue_drained", req_q.size(), 0);
        chk("cpl_queue_drained", cpl_q.size(), 0);
        chk("mis_queue_drained", mis_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the REQ-state cycle limit before abort; used only when MEM_TIMEOUT_EN is defined.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 MemRead_M  input  1  load request from the EX/MEM register.
REQ-005 MemWrite_M  input  1  store request from the EX/MEM register.
REQ-006 ALUResult_M  input  32  byte address of the access.
REQ-007 WriteData_M  input  32  store data.
REQ-008 mem_req  output  1  request to data memory, registered.
REQ-009 mem_we  output  1  1 = write, 0 = read, registered.
REQ-010 mem_addr  output  32  registered address.
REQ-011 mem_wdata  output  32  registered write data.
REQ-012 mem_ack  input  1  one-cycle completion strobe from memory.
REQ-013 mem_rdata  input  32  read data, valid when mem_ack=1.
REQ-014 ReadData_M  output  32  registered load result, feeding the MEM/WB register.
REQ-015 stall_M  output  1  combinational; freezes IF through EX/MEM and bubbles MEM/WB.
REQ-016 misalign_M  output  1  registered one-cycle pulse for a misaligned access.
REQ-017 mem_err  output  1  registered one-cycle pulse for a timeout abort.

Function
REQ-018 FSM states SHALL be IDLE, REQ and DONE.
REQ-019 IDLE with (MemRead_M | MemWrite_M) and ALUResult_M[1:0]==0: SHALL latch mem_addr, mem_wdata and mem_we=MemWrite_M, set mem_req=1, and go to REQ.
REQ-020 MemRead_M and MemWrite_M both high SHALL be handled as a write.
REQ-021 IDLE with an access and ALUResult_M[1:0]!=0: SHALL pulse misalign_M, issue no request, hold ReadData_M=0, not stall, and stay in IDLE.
REQ-022 stall_M SHALL be 1 in IDLE when an aligned access is present, and 1 throughout REQ.
REQ-023 stall_M SHALL be 0 in DONE and in IDLE with no access or a misaligned access.
REQ-024 In REQ, mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable until mem_ack.
REQ-025 REQ with mem_ack=1: SHALL clear mem_req, capture mem_rdata into ReadData_M (reads only; writes leave it unchanged), and go to DONE.
REQ-026 DONE SHALL last exactly one cycle and then go to IDLE, so each instruction issues exactly one request.
REQ-027 Minimum access latency SHALL be 3 cycles: IDLE, REQ with ack, DONE.
REQ-028 mem_ack SHALL be ignored in IDLE and DONE.

Reset
REQ-029 rst=1 SHALL force state=IDLE.
REQ-030 rst=1 SHALL zero mem_req, mem_we, mem_addr, mem_wdata, ReadData_M, misalign_M, mem_err and the timeout counter on the next edge.
REQ-031 rst asserted in REQ SHALL abandon the access with mem_req=0 the following cycle; a later mem_ack SHALL be ignored.
REQ-032 stall_M SHALL be 0 while rst=1.

Configuration
REQ-033 With MEM_TIMEOUT_EN defined, a counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-034 With MEM_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL drop mem_req, pulse mem_err, set ReadData_M=0 and go to DONE.
REQ-035 With MEM_TIMEOUT_EN defined, mem_ack in the same cycle as the timeout SHALL win, giving a normal completion with no mem_err.
REQ-036 Without MEM_TIMEOUT_EN, REQ SHALL wait indefinitely, mem_err SHALL be constant 0, and no counter SHALL be implemented.

Verification
REQ-037 Load at 0x00000010, mem_ack on 1st REQ cycle with rdata 0xCAFEF00D -> stall_M high 2 cycles, ReadData_M=0xCAFEF00D in DONE, exactly one mem_req.
REQ-038 Store 0x12345678 at 0x00000020, ack after 5 REQ cycles -> mem_we=1, address and data stable all 5 cycles, stall_M high 6 cycles, ReadData_M unchanged.
REQ-039 Load at 0x00000013 -> misalign_M one-cycle pulse, mem_req never asserted, stall_M=0.
REQ-040 rst pulsed during the 2nd REQ cycle, then mem_ack -> mem_req=0 after reset, state IDLE, all outputs 0, ack ignored.
REQ-041 MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, no ack -> mem_err pulse after 4 REQ cycles, then DONE then IDLE.
REQ-042 MEM_TIMEOUT_EN defined, ack coincident with the timeout -> normal completion, mem_err stays 0.
REQ-043 Back-to-back loads to 0x0 and 0x4 -> two distinct requests separated by a DONE cycle.
